// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO serial config loader.
// Pad config field map, loader FSM states and a sizing helper.
package gpio_cfg_pkg;

  localparam int CFG_W = 13;

  localparam int MGMT_EN = 0;
  localparam int OEB     = 1;
  localparam int HLD_OVR = 2;
  localparam int INP_DIS = 3;
  localparam int IB_SEL  = 4;
  localparam int ANA_EN  = 5;
  localparam int ANA_SEL = 6;
  localparam int ANA_POL = 7;
  localparam int SLOW    = 8;
  localparam int VTRIP   = 9;
  localparam int DM_LSB  = 10;
  localparam int DM_MSB  = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD,
    ST_DONE
  } ld_state_e;

  function automatic int max_i(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gpio_serial_loader_if.sv
// Request/status bundle between housekeeping and the chain loader.
// Master requests transfers; slave reports busy/done.
interface gpio_serial_loader_if #(
  parameter int TOTAL_PADS = 38,
  parameter int CFG_W      = 13
) ();

  logic                        xfer_start;
  logic [TOTAL_PADS*CFG_W-1:0] cfg_data;
  logic                        busy;
  logic                        done;

  modport master (
    output xfer_start,
    output cfg_data,
    input  busy,
    input  done
  );

  modport slave (
    input  xfer_start,
    input  cfg_data,
    output busy,
    output done
  );

endinterface

// File: rtl/gpio_serial_clkgen.sv
// Phase timer for the serial clock: strobes phase_end_o on the
// last wb cycle of every CLK_DIV-long phase while enabled.
module gpio_serial_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_i,
  output logic phase_end_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign phase_end_o = en_i && (cnt_q == TERM);

  // Count within a phase; restart on phase end or when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || phase_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Snapshots per-pad config words and shifts them out on two
// pad chains, then pulses serial_load to latch all pads at once.
module gpio_serial_loader
  import gpio_cfg_pkg::*;
#(
  parameter int AREA1PADS  = 19,
  parameter int TOTAL_PADS = 38,
  parameter int CFG_W      = gpio_cfg_pkg::CFG_W,
  parameter int CLK_DIV    = 4
) (
  input  logic wb_clk_i,
  input  logic wb_rstn_i,
  gpio_serial_loader_if.slave bus,
  output logic serial_clock,
  output logic serial_load,
  output logic serial_resetn,
  output logic serial_data_1,
  output logic serial_data_2
);

  localparam int L1   = AREA1PADS;
  localparam int L2   = TOTAL_PADS - AREA1PADS;
  localparam int PMAX = max_i(L1, L2);
  localparam int N    = PMAX * CFG_W;
  localparam int BW   = $clog2(N + 1);
  localparam logic [BW-1:0] LAST = BW'(N - 1);

  ld_state_e       state_q;
  ld_state_e       state_d;
  logic [N-1:0]    sr1_q;
  logic [N-1:0]    sr1_d;
  logic [N-1:0]    sr2_q;
  logic [N-1:0]    sr2_d;
  logic [BW-1:0]   bcnt_q;
  logic [BW-1:0]   bcnt_d;
  logic            rstn_q;
  logic [N-1:0]    snap1;
  logic [N-1:0]    snap2;
  logic            phase_end;
  logic            active;

  assign active = (state_q == ST_SHIFT_LO) ||
                  (state_q == ST_SHIFT_HI) ||
                  (state_q == ST_LOAD);

  gpio_serial_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_i       (wb_clk_i),
    .rstn_i      (wb_rstn_i),
    .en_i        (active),
    .phase_end_o (phase_end)
  );

  // Arrange pads so the MSB end leaves first; short chain gets
  // zero padding at the top, which falls off its far end.
  always_comb begin
    snap1 = '0;
    snap2 = '0;
    for (int i = 0; i < L1; i++) begin
      snap1[i*CFG_W +: CFG_W] = bus.cfg_data[i*CFG_W +: CFG_W];
    end
    for (int j = 0; j < L2; j++) begin
      snap2[j*CFG_W +: CFG_W] =
        bus.cfg_data[(TOTAL_PADS-1-j)*CFG_W +: CFG_W];
    end
  end

  // Next-state logic; shift registers move only when re-entering
  // SHIFT_LO so the data lines hold their last bit afterwards.
  always_comb begin
    state_d = state_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.xfer_start) begin
          state_d = ST_SHIFT_LO;
          sr1_d   = snap1;
          sr2_d   = snap2;
          bcnt_d  = '0;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_end) begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_end) begin
          if (bcnt_q == LAST) begin
            state_d = ST_LOAD;
            bcnt_d  = bcnt_q + 1'b1;
          end else begin
            state_d = ST_SHIFT_LO;
            bcnt_d  = bcnt_q + 1'b1;
            sr1_d   = {sr1_q[N-2:0], 1'b0};
            sr2_d   = {sr2_q[N-2:0], 1'b0};
          end
        end
      end
      ST_LOAD: begin
        if (phase_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, shift chains and bit counter.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q <= ST_IDLE;
      sr1_q   <= '0;
      sr2_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Chain reset follows the bus reset one cycle later.
  always_ff @(posedge wb_clk_i) begin
    rstn_q <= wb_rstn_i;
  end

  assign bus.busy      = active;
  assign bus.done      = (state_q == ST_DONE);
  assign serial_clock  = (state_q == ST_SHIFT_HI);
  assign serial_load   = (state_q == ST_LOAD);
  assign serial_resetn = rstn_q;
  assign serial_data_1 = sr1_q[N-1];
  assign serial_data_2 = sr2_q[N-1];

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: scoreboard of expected chain bits
// against bits captured on serial_clock rising edges.
module tb_gpio_serial_loader;

  localparam int A1 = 2;
  localparam int TP = 3;
  localparam int W  = 13;
  localparam int N  = 26;
  localparam int CW = TP * W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  gpio_serial_loader_if #(.TOTAL_PADS(TP), .CFG_W(W)) busA ();
  gpio_serial_loader_if #(.TOTAL_PADS(TP), .CFG_W(W)) busB ();

  logic a_sclk, a_load, a_rst, a_sd1, a_sd2;
  logic b_sclk, b_load, b_rst, b_sd1, b_sd2;

  gpio_serial_loader #(
    .AREA1PADS(A1), .TOTAL_PADS(TP), .CFG_W(W), .CLK_DIV(1)
  ) dutA (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .bus(busA),
    .serial_clock(a_sclk), .serial_load(a_load),
    .serial_resetn(a_rst),
    .serial_data_1(a_sd1), .serial_data_2(a_sd2)
  );

  gpio_serial_loader #(
    .AREA1PADS(A1), .TOTAL_PADS(TP), .CFG_W(W), .CLK_DIV(4)
  ) dutB (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .bus(busB),
    .serial_clock(b_sclk), .serial_load(b_load),
    .serial_resetn(b_rst),
    .serial_data_1(b_sd1), .serial_data_2(b_sd2)
  );

  int n_assert = 0;
  int n_fail = 0;

  bit   expA1[$], expA2[$], expB1[$], expB2[$];
  logic obsA1[$], obsA2[$], obsB1[$], obsB2[$];
  int rdA = 0;
  int rdB = 0;

  logic a_sclk_p = 1'b0;
  int a_load_cnt = 0, a_done_cnt = 0;
  logic b_sclk_p = 1'b0, b_busy_p = 1'b0;
  logic b_sd1_p = 1'b0, b_sd2_p = 1'b0;
  int b_hi = 0, b_lo = 0, b_viol = 0, b_busy_cnt = 0;

  always @(negedge clk) begin
    if (a_sclk === 1'b1 && a_sclk_p !== 1'b1) begin
      obsA1.push_back(a_sd1);
      obsA2.push_back(a_sd2);
    end
    a_sclk_p = a_sclk;
    if (a_load === 1'b1) a_load_cnt++;
    if (busA.done === 1'b1) a_done_cnt++;
  end

  always @(negedge clk) begin
    if (busB.busy === 1'b1) b_busy_cnt++;
    if (b_sclk === 1'b1 && b_sclk_p !== 1'b1) begin
      obsB1.push_back(b_sd1);
      obsB2.push_back(b_sd2);
      if (b_lo != 4) b_viol++;
      b_lo = 0;
    end
    if (b_sclk !== 1'b1 && b_sclk_p === 1'b1) begin
      if (b_hi != 4) b_viol++;
      b_hi = 0;
    end
    if (b_sclk === 1'b1) b_hi++;
    else if (busB.busy === 1'b1 && b_load !== 1'b1) b_lo++;
    if (busB.busy === 1'b1 && b_busy_p === 1'b1 &&
        (b_sd1 !== b_sd1_p || b_sd2 !== b_sd2_p) &&
        !(b_sclk_p === 1'b1 && b_sclk === 1'b0))
      b_viol++;
    b_sclk_p = b_sclk;
    b_busy_p = busB.busy;
    b_sd1_p  = b_sd1;
    b_sd2_p  = b_sd2;
  end

  function automatic logic [CW-1:0] rnd_cfg();
    return {7'($urandom), 32'($urandom)};
  endfunction

  task automatic push_bit(input bit isB, input bit ch2, input bit v);
    if (!isB && !ch2) expA1.push_back(v);
    if (!isB &&  ch2) expA2.push_back(v);
    if ( isB && !ch2) expB1.push_back(v);
    if ( isB &&  ch2) expB2.push_back(v);
  endtask

  task automatic push_exp(input bit isB, input logic [CW-1:0] cfg);
    logic [W-1:0] w;
    for (int k = 0; k < N - A1*W; k++) push_bit(isB, 1'b0, 1'b0);
    for (int p = A1-1; p >= 0; p--) begin
      w = cfg[p*W +: W];
      for (int b = W-1; b >= 0; b--) push_bit(isB, 1'b0, w[b]);
    end
    for (int k = 0; k < N - (TP-A1)*W; k++) push_bit(isB, 1'b1, 1'b0);
    for (int p = A1; p < TP; p++) begin
      w = cfg[p*W +: W];
      for (int b = W-1; b >= 0; b--) push_bit(isB, 1'b1, w[b]);
    end
  endtask

  task automatic drain(input bit isB,
                       output logic [63:0] e1, output logic [63:0] o1,
                       output logic [63:0] e2, output logic [63:0] o2,
                       output int ne, output int no);
    e1 = '0; o1 = '0; e2 = '0; o2 = '0; ne = 0; no = 0;
    if (!isB) begin
      while (expA1.size() > 0) begin
        e1 = {e1[62:0], expA1.pop_front()};
        e2 = {e2[62:0], expA2.pop_front()};
        ne++;
      end
      while (rdA < obsA1.size()) begin
        o1 = {o1[62:0], obsA1[rdA]};
        o2 = {o2[62:0], obsA2[rdA]};
        rdA++;
        no++;
      end
    end else begin
      while (expB1.size() > 0) begin
        e1 = {e1[62:0], expB1.pop_front()};
        e2 = {e2[62:0], expB2.pop_front()};
        ne++;
      end
      while (rdB < obsB1.size()) begin
        o1 = {o1[62:0], obsB1[rdB]};
        o2 = {o2[62:0], obsB2[rdB]};
        rdB++;
        no++;
      end
    end
  endtask

  task automatic wait_done(input bit isB, input int budget,
                           output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    while (cyc < budget && !ok) begin
      @(negedge clk);
      cyc++;
      if ((isB ? busB.done : busA.done) === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [6:0] va, vb;
    rstn = 1'b0;
    busA.xfer_start = 1'b0; busA.cfg_data = '0;
    busB.xfer_start = 1'b0; busB.cfg_data = '0;
    repeat (3) @(negedge clk);
    va = {busA.busy, busA.done, a_sclk, a_load, a_rst, a_sd1, a_sd2};
    vb = {busB.busy, busB.done, b_sclk, b_load, b_rst, b_sd1, b_sd2};
    n_assert++;
    if (va !== 7'b0) begin
      n_fail++; $display("FAIL reset_A got %b want 0000000", va);
    end
    n_assert++;
    if (vb !== 7'b0) begin
      n_fail++; $display("FAIL reset_B got %b want 0000000", vb);
    end
    rstn = 1'b1;
    n_assert++;
    if (a_rst !== 1'b0) begin
      n_fail++; $display("FAIL resetn_at_release got %b want 0", a_rst);
    end
    @(negedge clk);
    n_assert++;
    if ({a_rst, b_rst} !== 2'b11) begin
      n_fail++; $display("FAIL resetn_rise got %b want 11", {a_rst, b_rst});
    end
  endtask

  task automatic test_basic();
    logic [CW-1:0] cfg;
    logic [63:0] e1, o1, e2, o2;
    int ne, no, cyc, ld0, dn0;
    bit ok;
    cfg = {13'h1FFF, 13'h0403, 13'h1ABC};
    busA.cfg_data = cfg;
    push_exp(1'b0, cfg);
    ld0 = a_load_cnt; dn0 = a_done_cnt;
    busA.xfer_start = 1'b1;
    @(negedge clk);
    busA.xfer_start = 1'b0;
    n_assert++;
    if (busA.busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_start got %b want 1", busA.busy);
    end
    wait_done(1'b0, 200, cyc, ok);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL basic_timeout got no done want done");
    end
    n_assert++;
    if (cyc + 1 != 54) begin
      n_fail++; $display("FAIL basic_done_cycle got %0d want 54", cyc + 1);
    end
    n_assert++;
    if ({busA.busy, a_sd1, a_sd2} !== {1'b0, cfg[0], cfg[2*W]}) begin
      n_fail++;
      $display("FAIL basic_hold got %b want %b",
               {busA.busy, a_sd1, a_sd2}, {1'b0, cfg[0], cfg[2*W]});
    end
    @(negedge clk);
    n_assert++;
    if (a_load_cnt - ld0 != 1) begin
      n_fail++; $display("FAIL basic_load_len got %0d want 1", a_load_cnt - ld0);
    end
    n_assert++;
    if (a_done_cnt - dn0 != 1) begin
      n_fail++; $display("FAIL basic_done_cnt got %0d want 1", a_done_cnt - dn0);
    end
    drain(1'b0, e1, o1, e2, o2, ne, no);
    n_assert++;
    if (no != ne || ne != N) begin
      n_fail++; $display("FAIL basic_edges got %0d want %0d", no, ne);
    end
    n_assert++;
    if (o1 !== e1) begin
      n_fail++; $display("FAIL basic_chain1 got %h want %h", o1, e1);
    end
    n_assert++;
    if (o2 !== e2) begin
      n_fail++; $display("FAIL basic_chain2 got %h want %h", o2, e2);
    end
  endtask

  task automatic test_timing();
    logic [CW-1:0] cfg;
    logic [63:0] e1, o1, e2, o2;
    int ne, no, cyc, bz0, v0;
    bit ok;
    cfg = rnd_cfg();
    busB.cfg_data = cfg;
    push_exp(1'b1, cfg);
    bz0 = b_busy_cnt; v0 = b_viol;
    busB.xfer_start = 1'b1;
    @(negedge clk);
    busB.xfer_start = 1'b0;
    wait_done(1'b1, 400, cyc, ok);
    @(negedge clk);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL timing_timeout got no done want done");
    end
    n_assert++;
    if (b_busy_cnt - bz0 != 2*4*N + 4) begin
      n_fail++;
      $display("FAIL timing_busy got %0d want %0d", b_busy_cnt - bz0, 2*4*N + 4);
    end
    n_assert++;
    if (b_viol - v0 != 0) begin
      n_fail++; $display("FAIL timing_phase got %0d want 0", b_viol - v0);
    end
    drain(1'b1, e1, o1, e2, o2, ne, no);
    n_assert++;
    if (no != ne || o1 !== e1 || o2 !== e2) begin
      n_fail++;
      $display("FAIL timing_data got %0d %h %h want %0d %h %h",
               no, o1, o2, ne, e1, e2);
    end
  endtask

  task automatic test_snapshot();
    logic [CW-1:0] cfg;
    logic [63:0] e1, o1, e2, o2;
    int ne, no, cyc, dn0;
    bit ok;
    cfg = rnd_cfg();
    busA.cfg_data = cfg;
    push_exp(1'b0, cfg);
    dn0 = a_done_cnt;
    busA.xfer_start = 1'b1;
    @(negedge clk);
    busA.xfer_start = 1'b0;
    repeat (10) @(negedge clk);
    busA.cfg_data = ~cfg;
    busA.xfer_start = 1'b1;
    repeat (3) @(negedge clk);
    busA.xfer_start = 1'b0;
    wait_done(1'b0, 200, cyc, ok);
    @(negedge clk);
    n_assert++;
    if (!ok) begin
      n_fail++; $display("FAIL snap_timeout got no done want done");
    end
    drain(1'b0, e1, o1, e2, o2, ne, no);
    n_assert++;
    if (no != ne || o1 !== e1 || o2 !== e2) begin
      n_fail++;
      $display("FAIL snap_data got %0d %h %h want %0d %h %h",
               no, o1, o2, ne, e1, e2);
    end
    repeat (60) @(negedge clk);
    n_assert++;
    if (a_done_cnt - dn0 != 1 || obsA1.size() != rdA) begin
      n_fail++;
      $display("FAIL snap_single got %0d dones %0d extra bits want 1 0",
               a_done_cnt - dn0, obsA1.size() - rdA);
    end
  endtask

  task automatic test_abort();
    logic [CW-1:0] cfg;
    logic [63:0] e1, o1, e2, o2;
    int ne, no, cyc, ld0, dn0;
    bit ok;
    busA.cfg_data = rnd_cfg();
    ld0 = a_load_cnt; dn0 = a_done_cnt;
    busA.xfer_start = 1'b1;
    @(negedge clk);
    busA.xfer_start = 1'b0;
    cyc = 0;
    while (obsA1.size() - rdA < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if (obsA1.size() - rdA < 10) begin
      n_fail++;
      $display("FAIL abort_reach got %0d bits want 10", obsA1.size() - rdA);
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    n_assert++;
    if ({busA.busy, busA.done, a_sclk} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_idle got %b want 000", {busA.busy, busA.done, a_sclk});
    end
    repeat (60) @(negedge clk);
    n_assert++;
    if (a_load_cnt != ld0 || a_done_cnt != dn0) begin
      n_fail++;
      $display("FAIL abort_quiet got load %0d done %0d want 0 0",
               a_load_cnt - ld0, a_done_cnt - dn0);
    end
    rdA = obsA1.size();
    cfg = rnd_cfg();
    busA.cfg_data = cfg;
    push_exp(1'b0, cfg);
    busA.xfer_start = 1'b1;
    @(negedge clk);
    busA.xfer_start = 1'b0;
    wait_done(1'b0, 200, cyc, ok);
    @(negedge clk);
    drain(1'b0, e1, o1, e2, o2, ne, no);
    n_assert++;
    if (!ok || no != ne || o1 !== e1 || o2 !== e2) begin
      n_fail++;
      $display("FAIL abort_recover got %0d %0d %h %h want 1 %0d %h %h",
               ok, no, o1, o2, ne, e1, e2);
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] cfg;
    logic [63:0] e1, o1, e2, o2;
    int ne, no, cyc, dn0;
    bit ok;
    cfg = rnd_cfg();
    busA.cfg_data = cfg;
    push_exp(1'b0, cfg);
    push_exp(1'b0, cfg);
    dn0 = a_done_cnt;
    busA.xfer_start = 1'b1;
    wait_done(1'b0, 200, cyc, ok);
    n_assert++;
    if (!ok || busA.busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first got %0d %b want 1 0", ok, busA.busy);
    end
    @(negedge clk);
    n_assert++;
    if ({busA.busy, busA.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_gap got %b want 00", {busA.busy, busA.done});
    end
    @(negedge clk);
    busA.xfer_start = 1'b0;
    n_assert++;
    if (busA.busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart got %b want 1", busA.busy);
    end
    wait_done(1'b0, 200, cyc, ok);
    n_assert++;
    if (!ok || cyc != 53) begin
      n_fail++; $display("FAIL b2b_second got %0d %0d want 1 53", ok, cyc);
    end
    @(negedge clk);
    drain(1'b0, e1, o1, e2, o2, ne, no);
    n_assert++;
    if (no != ne || ne != 2*N || o1 !== e1 || o2 !== e2) begin
      n_fail++;
      $display("FAIL b2b_data got %0d %h %h want %0d %h %h",
               no, o1, o2, ne, e1, e2);
    end
    n_assert++;
    if (a_done_cnt - dn0 != 2) begin
      n_fail++; $display("FAIL b2b_dones got %0d want 2", a_done_cnt - dn0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timing();
    test_snapshot();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
